sr_muldiv_seq: RTL

- Iterative, one-bit-per-cycle unsigned multiply/divide unit on the CPU writeback side.
- Consumes the two register-file read operands. Produces a WIDTH-bit result for the register write-data mux.
- Uses the same start/busy handshake as the existing multi-cycle arithmetic unit, so control can stall the PC while busy is high.
- Operation is selected directly by the RISC-V M-extension funct3.

---
 rtl/sr_muldiv_seq.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/sr_muldiv_seq.sv
// Iterative one-bit-per-cycle unsigned MUL/MULHU/DIVU/REMU unit with a start/busy handshake.
// Define SR_MULDIV_EARLY_OUT_EN to finish trivial operands at accept without iterating.
module sr_muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_MULHU = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b101;
    localparam logic [2:0] OP_REMU  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, stateNext;

    logic [2:0]       opQ;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] accHi;
    logic [WIDTH-1:0] accLo;
    logic [WIDTH-1:0] opnd;

    // Handshake: start is taken on any rising edge where the unit is not in RUN.
    // busy is high for every RUN cycle; valid is high for the single DONE cycle.
    logic accept;
    logic lastIter;
    assign accept   = start && (state != S_RUN);
    assign lastIter = (state == S_RUN) && (cnt == LAST_ITER);

    assign busy  = (state == S_RUN);
    assign valid = (state == S_DONE);

    function automatic logic isDivOp(input logic [2:0] o);
        return (o == OP_DIVU) || (o == OP_REMU);
    endfunction

    function automatic logic [WIDTH-1:0] selResult(
        input logic [2:0]       o,
        input logic [WIDTH-1:0] hi,
        input logic [WIDTH-1:0] lo
    );
        logic [WIDTH-1:0] r;
        r = '0;
        case (o)
            OP_MUL:   r = lo;
            OP_MULHU: r = hi;
            OP_DIVU:  r = lo;
            OP_REMU:  r = hi;
            default:  r = '0;
        endcase
        return r;
    endfunction

    // Multiply: {accHi, accLo} is the product; accLo starts as the multiplier
    // and its LSB picks whether the multiplicand is added before the right shift.
    logic [WIDTH:0]   mulSum;
    logic [WIDTH-1:0] mulHi;
    logic [WIDTH-1:0] mulLo;

    always_comb begin
        mulSum = {1'b0, accHi} + (accLo[0] ? {1'b0, opnd} : {(WIDTH + 1){1'b0}});
        mulHi  = mulSum[WIDTH:1];
        mulLo  = {mulSum[0], accLo[WIDTH-1:1]};
    end

    // Divide: accHi is the partial remainder, accLo shifts dividend bits out
    // at the top and quotient bits in at the bottom. A zero divisor naturally
    // yields an all-ones quotient and the dividend as remainder.
    logic [WIDTH:0]   divShift;
    logic             divGe;
    logic [WIDTH-1:0] divSub;
    logic [WIDTH-1:0] divHi;
    logic [WIDTH-1:0] divLo;

    always_comb begin
        divShift = {accHi, accLo[WIDTH-1]};
        divGe    = (divShift >= {1'b0, opnd});
        divSub   = divShift[WIDTH-1:0] - opnd;
        divHi    = divGe ? divSub : divShift[WIDTH-1:0];
        divLo    = {accLo[WIDTH-2:0], divGe};
    end

    logic [WIDTH-1:0] stepHi;
    logic [WIDTH-1:0] stepLo;

    always_comb begin
        stepHi = mulHi;
        stepLo = mulLo;
        if (isDivOp(opQ)) begin
            stepHi = divHi;
            stepLo = divLo;
        end
    end

    logic             earlyHit;
    logic [WIDTH-1:0] earlyResult;

`ifdef SR_MULDIV_EARLY_OUT_EN
    always_comb begin
        earlyHit    = 1'b0;
        earlyResult = '0;
        case (op)
            OP_MUL, OP_MULHU: begin
                if ((srcA == '0) || (srcB == '0)) begin
                    earlyHit    = 1'b1;
                    earlyResult = '0;
                end
            end
            OP_DIVU: begin
                if (srcB == '0) begin
                    earlyHit    = 1'b1;
                    earlyResult = '1;
                end else if (srcB == WIDTH'(1)) begin
                    earlyHit    = 1'b1;
                    earlyResult = srcA;
                end
            end
            OP_REMU: begin
                if (srcB == '0) begin
                    earlyHit    = 1'b1;
                    earlyResult = srcA;
                end else if (srcB == WIDTH'(1)) begin
                    earlyHit    = 1'b1;
                    earlyResult = '0;
                end
            end
            default: begin
                earlyHit    = 1'b0;
                earlyResult = '0;
            end
        endcase
    end
`else
    assign earlyHit    = 1'b0;
    assign earlyResult = '0;
`endif

    always_comb begin
        stateNext = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    stateNext = earlyHit ? S_DONE : S_RUN;
                end else begin
                    stateNext = S_IDLE;
                end
            end
            S_RUN: begin
                if (cnt == LAST_ITER) begin
                    stateNext = S_DONE;
                end
            end
            default: stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opQ    <= '0;
            cnt    <= '0;
            accHi  <= '0;
            accLo  <= '0;
            opnd   <= '0;
            result <= '0;
        end else if (accept) begin
            opQ   <= op;
            cnt   <= '0;
            accHi <= '0;
            if (isDivOp(op)) begin
                opnd  <= srcB;
                accLo <= srcA;
            end else begin
                opnd  <= srcA;
                accLo <= srcB;
            end
            if (earlyHit) begin
                result <= earlyResult;
            end
        end else if (state == S_RUN) begin
            accHi <= stepHi;
            accLo <= stepLo;
            cnt   <= cnt + CW'(1);
            if (lastIter) begin
                result <= selResult(opQ, stepHi, stepLo);
            end
        end
    end

endmodule
